// File: rtl/snake_vga_render.sv
// Snake display: 640x480 VGA timing plus per-cell RGB444 drawn from a once-per-frame game snapshot.
// Outputs lag the counters by one pixel tick; no backpressure, inputs are sampled only at frame end.
module snake_vga_render #(
    parameter int unsigned PIX_DIV      = 4,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned H_SYNC_START = 656,
    parameter int unsigned H_SYNC_END   = 752,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_TOTAL      = 525,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned V_SYNC_END   = 492
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [95:0] seg_x,
    input  logic [95:0] seg_y,
    input  logic [4:0]  seg_len,
    input  logic [5:0]  food_x,
    input  logic [5:0]  food_y,
    input  logic        is_over,
    input  logic        is_win,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start,
    output logic        active
);
    logic [3:0]  r_div;
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [95:0] r_seg_x;
    logic [95:0] r_seg_y;
    logic [4:0]  r_len;
    logic [5:0]  r_food_x;
    logic [5:0]  r_food_y;
    logic        r_over;
    logic        r_win;

    logic        w_tick;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_snap;
    logic [4:0]  w_len_sat;
    logic [5:0]  w_cx;
    logic [5:0]  w_cy;
    logic        w_visible;
    logic        w_in_grid;
    logic        w_border;
    logic        w_food;
    logic [15:0] w_hit;
    logic [11:0] w_rgb;

    assign w_tick    = (r_div == 4'(PIX_DIV - 1));
    assign w_h_last  = (r_h_cnt == 10'(H_TOTAL - 1));
    assign w_v_last  = (r_v_cnt == 10'(V_TOTAL - 1));
    assign w_snap    = w_tick && w_h_last && w_v_last;
    assign w_len_sat = (seg_len == 5'd0) ? 5'd1 : (seg_len > 5'd16) ? 5'd16 : seg_len;

    assign w_cx      = r_h_cnt[9:4];
    assign w_cy      = r_v_cnt[9:4];
    assign w_visible = (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
    // Off-grid coordinates must never draw, even if the timing exposes more than 40x30 cells.
    assign w_in_grid = (w_cx < 6'd40) && (w_cy < 6'd30);
    assign w_border  = (w_cx == 6'd0) || (w_cx == 6'd39) || (w_cy == 6'd0) || (w_cy == 6'd29);
    assign w_food    = w_in_grid && (r_food_x == w_cx) && (r_food_y == w_cy);

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < 16; i++) begin
            w_hit[i] = w_in_grid && (5'(i) < r_len) &&
                       (r_seg_x[6*i +: 6] == w_cx) && (r_seg_y[6*i +: 6] == w_cy);
        end
    end

    always_comb begin
        w_rgb = 12'h000;
        if (w_visible) begin
            if (r_win)              w_rgb = 12'h0F0;
            else if (r_over)        w_rgb = 12'hF00;
            else if (w_hit[0])      w_rgb = 12'hFF0;
            else if (|w_hit[15:1])  w_rgb = 12'h0A0;
            else if (w_food)        w_rgb = 12'hF0F;
            else if (w_border)      w_rgb = 12'hFFF;
            else                    w_rgb = 12'h000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_div <= w_tick ? 4'd0 : r_div + 4'd1;
            if (w_tick) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_x  <= '0;
            r_seg_y  <= '0;
            r_len    <= 5'd1;
            r_food_x <= '0;
            r_food_y <= '0;
            r_over   <= 1'b0;
            r_win    <= 1'b0;
        end else if (w_snap) begin
            r_seg_x  <= seg_x;
            r_seg_y  <= seg_y;
            r_len    <= w_len_sat;
            r_food_x <= food_x;
            r_food_y <= food_y;
            r_over   <= is_over;
            r_win    <= is_win;
        end
    end

    // All pixel outputs come from one counter value so sync and colour never skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            active      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_snap;
            if (w_tick) begin
                hsync  <= !((r_h_cnt >= 10'(H_SYNC_START)) && (r_h_cnt < 10'(H_SYNC_END)));
                vsync  <= !((r_v_cnt >= 10'(V_SYNC_START)) && (r_v_cnt < 10'(V_SYNC_END)));
                {vga_r, vga_g, vga_b} <= w_rgb;
                active <= w_visible;
            end
        end
    end
endmodule

// File: tb/tb_snake_vga_render.sv
// Bench for snake_vga_render on shrunken timing; outputs compared every clk against a cycle-count model.
module tb_snake_vga_render;
    localparam int PD  = 2;
    localparam int HA  = 96;
    localparam int HSS = 97;
    localparam int HSE = 99;
    localparam int HT  = 100;
    localparam int VA  = 36;
    localparam int VSS = 37;
    localparam int VSE = 39;
    localparam int VT  = 40;
    localparam int F   = HT * VT;
    localparam int LIM = 2 * F * PD + 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [95:0] seg_x = '0;
    logic [95:0] seg_y = '0;
    logic [4:0]  seg_len = '0;
    logic [5:0]  food_x = '0;
    logic [5:0]  food_y = '0;
    logic        is_over = 1'b0;
    logic        is_win = 1'b0;
    logic        hsync, vsync, frame_start, active;
    logic [3:0]  vga_r, vga_g, vga_b;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference state: clk edges since reset plus the game state seen at each frame boundary.
    int m_n = 0;
    int m_len = 1;
    int m_sx[16];
    int m_sy[16];
    int m_fx = 0;
    int m_fy = 0;
    bit m_over = 1'b0;
    bit m_win = 1'b0;

    snake_vga_render #(
        .PIX_DIV(PD), .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .seg_x(seg_x), .seg_y(seg_y), .seg_len(seg_len),
        .food_x(food_x), .food_y(food_y), .is_over(is_over), .is_win(is_win),
        .hsync(hsync), .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start), .active(active)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n <= 0;
            m_len <= 1;
            m_fx <= 0;
            m_fy <= 0;
            m_over <= 1'b0;
            m_win <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                m_sx[i] <= 0;
                m_sy[i] <= 0;
            end
        end else begin
            m_n <= m_n + 1;
            if (((m_n + 1) % PD == 0) && (((m_n + 1) / PD) % F == 0)) begin
                for (int i = 0; i < 16; i++) begin
                    m_sx[i] <= int'(seg_x[6*i +: 6]);
                    m_sy[i] <= int'(seg_y[6*i +: 6]);
                end
                m_len <= (seg_len == 5'd0) ? 1 : (seg_len > 5'd16) ? 16 : int'(seg_len);
                m_fx <= int'(food_x);
                m_fy <= int'(food_y);
                m_over <= is_over;
                m_win <= is_win;
            end
        end
    end

    function automatic logic [11:0] colour(input int cx, input int cy);
        bit g;
        g = (cx <= 39) && (cy <= 29);
        if (m_win) return 12'h0F0;
        if (m_over) return 12'hF00;
        if (g && m_sx[0] == cx && m_sy[0] == cy) return 12'hFF0;
        for (int i = 1; i < m_len; i++)
            if (g && m_sx[i] == cx && m_sy[i] == cy) return 12'h0A0;
        if (g && m_fx == cx && m_fy == cy) return 12'hF0F;
        if (cx == 0 || cx == 39 || cy == 0 || cy == 29) return 12'hFFF;
        return 12'h000;
    endfunction

    // {hsync, vsync, active, frame_start, rgb} expected after m_n edges.
    function automatic logic [15:0] exp_out();
        int t, q, h, v;
        logic hs, vs, act, fs;
        logic [11:0] rgb;
        t = m_n / PD;
        if (t == 0) return 16'hC000;
        q = (t - 1) % F;
        h = q % HT;
        v = q / HT;
        hs = !(h >= HSS && h < HSE);
        vs = !(v >= VSS && v < VSE);
        act = (h < HA) && (v < VA);
        fs = (m_n % PD == 0) && (t % F == 0);
        rgb = act ? colour(h / 16, v / 16) : 12'h000;
        return {hs, vs, act, fs, rgb};
    endfunction

    function automatic bit at_pos(input int x, input int y, input int f);
        int t;
        t = m_n / PD;
        return (t > 0) && ((t - 1) / F == f) && ((t - 1) % F == y * HT + x);
    endfunction

    task automatic wait_pix(input string tag, input int x, input int y, input int f);
        int k;
        k = 0;
        while (!at_pos(x, y, f) && k < LIM) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_reach"}, 32'(k < LIM), 32'd1);
    endtask

    task automatic pix(input string tag, input int x, input int y, input int f, input logic [11:0] exp);
        wait_pix(tag, x, y, f);
        chk(tag, 32'({vga_r, vga_g, vga_b}), 32'(exp));
    endtask

    task automatic set_seg(input int i, input int x, input int y);
        seg_x[6*i +: 6] = 6'(x);
        seg_y[6*i +: 6] = 6'(y);
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 7) == 0) set_seg(i, $urandom_range(40, 63), $urandom_range(0, 2));
            else set_seg(i, $urandom_range(0, 7), $urandom_range(0, 2));
        end
        seg_len = 5'($urandom_range(0, 31));
        food_x = 6'($urandom_range(0, 7));
        food_y = 6'($urandom_range(0, 2));
        is_over = ($urandom_range(0, 7) == 0);
        is_win = ($urandom_range(0, 7) == 0);
    endtask

    // Per-clk comparison plus sync/frame interval measurements.
    initial begin
        int cyc, last_hf, last_vf, last_fs;
        logic hs_prev, vs_prev;
        cyc = 0; last_hf = -1; last_vf = -1; last_fs = -1;
        hs_prev = 1'b1; vs_prev = 1'b1;
        wait (chk_en);
        forever begin
            @(negedge clk);
            chk("pix", 32'({hsync, vsync, active, frame_start, vga_r, vga_g, vga_b}), 32'(exp_out()));
            if (!rst_n) begin
                last_hf = -1; last_vf = -1; last_fs = -1;
            end else begin
                if (hs_prev && !hsync) begin
                    if (last_hf >= 0) chk("line_period", 32'(cyc - last_hf), 32'(HT * PD));
                    last_hf = cyc;
                end
                if (!hs_prev && hsync && last_hf >= 0) chk("hsync_width", 32'(cyc - last_hf), 32'((HSE - HSS) * PD));
                if (vs_prev && !vsync) last_vf = cyc;
                if (!vs_prev && vsync && last_vf >= 0) chk("vsync_width", 32'(cyc - last_vf), 32'((VSE - VSS) * HT * PD));
                if (frame_start) begin
                    if (last_fs >= 0) chk("frame_period", 32'(cyc - last_fs), 32'(F * PD));
                    last_fs = cyc;
                end
            end
            hs_prev = hsync;
            vs_prev = vsync;
            cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 3; i < 16; i++) set_seg(i, 63, 63);
        set_seg(0, 2, 1); set_seg(1, 1, 1); set_seg(2, 0, 1);
        food_x = 6'd4; food_y = 6'd1; seg_len = 5'd3;

        // First frame renders the reset snapshot: lone head at (0,0).
        pix("f0_head00", 0, 0, 0, 12'hFF0);
        pix("f0_border", 16, 0, 0, 12'hFFF);
        pix("f0_noseg", 32, 16, 0, 12'h000);

        pix("head", 0 + 32, 16, 1, 12'hFF0);
        pix("food", 64, 16, 1, 12'hF0F);
        pix("body_on_border", 5, 20, 1, 12'h0A0);
        pix("body", 17, 20, 1, 12'h0A0);
        pix("bg", 80, 20, 1, 12'h000);
        wait_pix("move", 0, 22, 1);
        set_seg(0, 3, 1);
        seg_len = 5'd0;
        pix("tear_body", 17, 24, 1, 12'h0A0);
        pix("tear_old", 32, 24, 1, 12'hFF0);
        pix("tear_new", 48, 24, 1, 12'h000);

        pix("len0_border", 5, 16, 2, 12'hFFF);
        pix("len0_body", 16, 16, 2, 12'h000);
        pix("len0_old", 32, 16, 2, 12'h000);
        pix("len0_head", 48, 16, 2, 12'hFF0);
        wait_pix("set20", 0, 36, 2);
        seg_len = 5'd20;
        set_seg(15, 5, 2);

        pix("len20_body", 16, 16, 3, 12'h0A0);
        pix("len20_food", 64, 16, 3, 12'hF0F);
        pix("len20_seg15", 85, 34, 3, 12'h0A0);
        wait_pix("set_over", 0, 36, 3);
        is_over = 1'b1;

        pix("over_blank", 96, 10, 4, 12'h000);
        pix("over_body", 16, 16, 4, 12'hF00);
        pix("over_cell", 85, 34, 4, 12'hF00);
        wait_pix("set_win", 0, 36, 4);
        is_win = 1'b1;

        pix("win_corner", 0, 0, 5, 12'h0F0);
        pix("win_mid", 40, 20, 5, 12'h0F0);
        pix("win_blank", 96, 20, 5, 12'h000);
        wait_pix("set_rand", 0, 36, 5);
        rand_inputs();

        for (int k = 0; k < 15; k++) begin
            repeat (300) @(negedge clk);
            rand_inputs();
        end

        // Reset in the middle of a line while hsync is low.
        wait_pix("mid_rst", 97, 30, 6);
        chk("pre_rst_hsync", 32'(hsync), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_hsync", 32'(hsync), 32'd1);
        chk("mid_rst_vsync", 32'(vsync), 32'd1);
        chk("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("mid_rst_active", 32'(active), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rand_inputs();
        pix("restart_head", 0, 0, 0, 12'hFF0);
        chk("restart_active", 32'(active), 32'd1);

        for (int k = 0; k < 45; k++) begin
            repeat (350) @(negedge clk);
            rand_inputs();
        end
        wait_pix("end", 0, 0, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/snake_vga_render.md
Name: snake_vga_render

Overview:
- Display end of the snake game datapath.
- Consumes the snake segment coordinates, food coordinate and game status produced by the game logic.
- Generates 640x480@60 VGA timing and per-pixel RGB444 colour for a 40x30 grid of 16x16-pixel cells.
- Latches all game inputs once per frame so that a mid-frame move never tears the picture.

Parameters:
- PIX_DIV, 4, clk cycles per pixel tick (100 MHz clk gives 25 MHz pixel rate); legal values 1..16.
- H_ACTIVE, 640, visible pixels per line.
- H_TOTAL, 800, pixel ticks per line.
- H_SYNC_START, 656, first hsync-low pixel.
- H_SYNC_END, 752, first pixel after hsync low.
- V_ACTIVE, 480, visible lines.
- V_TOTAL, 525, lines per frame.
- V_SYNC_START, 490, first vsync-low line.
- V_SYNC_END, 492, first line after vsync low.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- seg_x  in  96  segment x coordinates, 6 bits each; segment i is at [6i+5:6i]; segment 0 is the head.
- seg_y  in  96  segment y coordinates, same packing as seg_x.
- seg_len  in  5  number of valid segments, 1..16.
- food_x  in  6  food cell x coordinate.
- food_y  in  6  food cell y coordinate.
- is_over  in  1  game-over flag.
- is_win  in  1  game-won flag.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- vga_r  out  4  red.
- vga_g  out  4  green.
- vga_b  out  4  blue.
- frame_start  out  1  one-clk pulse when the snapshot is taken.
- active  out  1  high while the registered pixel is visible.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - tick divider=0, h_cnt=0, v_cnt=0.
  - hsync=1, vsync=1, vga_r/g/b=0, active=0, frame_start=0.
  - Snapshot registers: all coordinates 0, len 1, flags 0.
- Pixel tick:
  - Divider counts 0..PIX_DIV-1; tick asserts when divider==PIX_DIV-1.
  - With PIX_DIV=1, tick is high every cycle.
- Counters advance on tick only:
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0 and increments v_cnt.
  - v_cnt counts 0..V_TOTAL-1, then wraps to 0.
- Snapshot:
  - On the tick where (h_cnt,v_cnt)=(H_TOTAL-1,V_TOTAL-1), all game inputs are captured into shadow registers.
  - frame_start pulses for exactly that one clk.
  - The shadow registers are the only source for colour in the following frame.
- seg_len sanitising at capture:
  - 0 is stored as 1.
  - Values >16 are stored as 16.
- Cell mapping: cx=h_cnt[9:4], cy=v_cnt[9:4]; a segment matches when its shadow x==cx and y==cy and its index < len.
- Colour priority, highest first, for visible pixels (h_cnt<H_ACTIVE and v_cnt<V_ACTIVE):
  1. win: 0x0F0.
  2. over: 0xF00.
  3. head (segment 0): 0xFF0.
  4. body match: 0x0A0.
  5. food: 0xF0F.
  6. border cell (cx==0, cx==39, cy==0 or cy==29): 0xFFF.
  7. Otherwise background: 0x000.
- Non-visible pixels output 0x000.
- Coordinates outside the grid (x>39 or y>29) never match and are never drawn.
- Output registration:
  - hsync, vsync, RGB and active are all registered from the same h_cnt/v_cnt values, so they stay mutually aligned.
  - They update on the clk edge of the tick that follows the counter value, giving a fixed 1-pixel-tick latency.
- Sync polarity:
  - hsync is low for H_SYNC_START<=h_cnt<H_SYNC_END.
  - vsync is low for V_SYNC_START<=v_cnt<V_SYNC_END.
- Simultaneous events:
  - Input changes during a frame have no visible effect until the next snapshot.
  - If is_win and is_over are both high, win colour wins.
  - Head and food in the same cell: head colour.
- Reset mid-frame: all counters and outputs return to their reset values immediately; the first frame after reset renders from the reset-valued snapshot, with a single head at (0,0) drawn over the border.

Test Plan:
- Timing: after reset, run 2 frames with PIX_DIV=4.
  - Line period is 3200 clk; frame period is 1,680,000 clk.
  - hsync is low for 96 ticks, starting at tick 656 of each line.
  - vsync is low for lines 490-491.
  - frame_start occurs once per frame.
- Rendering: seg_len=3, segments (10,10),(9,10),(8,10), food (20,15), flags 0.
  - Pixel (160,160) is 0xFF0.
  - Pixel (144,165) is 0x0A0.
  - Pixel (320,240) is 0xF0F.
  - Pixel (0,0) is 0xFFF.
  - Pixel (300,100) is 0x000.
- Tearing: move the head to (11,10) at line 200.
  - The current frame still draws the head at (10,10).
  - The next frame draws it at (11,10).
- seg_len=0 and seg_len=20, with segment 15 at (5,5):
  - seg_len=0 draws only the head.
  - seg_len=20 draws the full 16 segments, including (5,5) as 0x0A0.
- Flags: is_over=1 gives all visible pixels 0xF00; is_over=1 with is_win=1 gives 0x0F0; blanking pixels stay 0x000.
- Reset: assert rst_n low at line 300, pixel 400.
  - Outputs immediately become hsync=1, vsync=1, RGB=0.
  - After release, counting restarts at (0,0).
